// File: rtl/normalize_round_if.sv
// Handshake and data bundle for the normalize/round stage.
// The upstream side (master) offers raw sums and the stage (slave) returns packed results.
interface normalize_round_if #(
    parameter int SIG_BITS = 23,
    parameter int EXP_BITS = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic                         sign_in;
    logic [EXP_BITS-1:0]          exp_in;
    logic [SIG_BITS+4:0]          sig_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [EXP_BITS+SIG_BITS:0]   result;
    logic                         overflow;
    logic                         underflow;
    logic                         inexact;

    modport master (
        output in_valid, sign_in, exp_in, sig_in, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, inexact
    );

    modport slave (
        input  in_valid, sign_in, exp_in, sig_in, out_ready,
        output in_ready, out_valid, result, overflow, underflow, inexact
    );
endinterface

// File: rtl/normalize_round.sv
// Post-add normalization (one bit per cycle) followed by round-to-nearest-even
// and overflow/underflow handling for the FP add/sub datapath.
module normalize_round #(
    parameter int SIG_BITS = 23,
    parameter int EXP_BITS = 8
) (
    input logic               clk,
    input logic               reset,
    normalize_round_if.slave  bus
);
    localparam int SW     = SIG_BITS + 5;
    localparam int CARRY  = SIG_BITS + 4;
    localparam int HIDDEN = SIG_BITS + 3;
    localparam logic [EXP_BITS:0] EXP_ONE = (EXP_BITS + 1)'(1);
    localparam logic [EXP_BITS:0] EXP_MAX = {1'b0, {EXP_BITS{1'b1}}};

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t                     state_q, state_d;
    logic                       sign_q, sign_d;
    logic [EXP_BITS:0]          exp_q, exp_d;
    logic [SW-1:0]              sig_q, sig_d;
    logic [EXP_BITS+SIG_BITS:0] result_q, result_d;
    logic                       overflow_q, overflow_d;
    logic                       underflow_q, underflow_d;
    logic                       inexact_q, inexact_d;

    logic                       roundUp;
    logic [SIG_BITS:0]          fracSum;
    logic [EXP_BITS:0]          roundExp;

    assign bus.in_ready  = (state_q == IDLE) && !reset;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.inexact   = inexact_q;

    // In ROUND the hidden bit is always set, so a carry out of the fraction
    // alone is the same as a carry out of {hidden, frac}.
    assign roundUp  = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);
    assign fracSum  = {1'b0, sig_q[HIDDEN-1:3]} + {{SIG_BITS{1'b0}}, roundUp};
    assign roundExp = exp_q + {{EXP_BITS{1'b0}}, fracSum[SIG_BITS]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            sig_q       <= '0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            sig_q       <= sig_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            inexact_q   <= inexact_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        sig_d       = sig_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        inexact_d   = inexact_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d      = bus.sign_in;
                    exp_d       = {1'b0, bus.exp_in};
                    sig_d       = bus.sig_in;
                    result_d    = '0;
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    inexact_d   = 1'b0;
                    state_d     = NORM;
                end
            end
            NORM: begin
                if (sig_q == '0) begin
                    result_d = {sign_q, {EXP_BITS{1'b0}}, {SIG_BITS{1'b0}}};
                    state_d  = DONE;
                end else if (sig_q[CARRY]) begin
                    // The bit shifted out of S is folded back in so stickiness is kept.
                    sig_d   = {1'b0, sig_q[SW-1:2], sig_q[1] | sig_q[0]};
                    exp_d   = exp_q + EXP_ONE;
                    state_d = ROUND;
                end else if (sig_q[HIDDEN]) begin
                    state_d = ROUND;
                end else if (exp_q <= EXP_ONE) begin
                    result_d    = {sign_q, {EXP_BITS{1'b0}}, {SIG_BITS{1'b0}}};
                    underflow_d = 1'b1;
                    inexact_d   = 1'b1;
                    state_d     = DONE;
                end else begin
                    sig_d = {sig_q[SW-2:0], 1'b0};
                    exp_d = exp_q - EXP_ONE;
                end
            end
            ROUND: begin
                inexact_d = |sig_q[2:0];
                if (roundExp >= EXP_MAX) begin
                    result_d   = {sign_q, {EXP_BITS{1'b1}}, {SIG_BITS{1'b0}}};
                    overflow_d = 1'b1;
                    inexact_d  = 1'b1;
                end else begin
                    result_d = {sign_q, roundExp[EXP_BITS-1:0], fracSum[SIG_BITS-1:0]};
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_normalize_round.sv
// Directed bench for normalize_round: a vector table of hand-computed results
// plus sequences for backpressure and mid-operation reset.
module tb_normalize_round;
    localparam int SIG_BITS = 23;
    localparam int EXP_BITS = 8;
    localparam int NUM_VEC  = 13;

    typedef struct {
        logic        signIn;
        logic [7:0]  expIn;
        logic [27:0] sigIn;
        logic [31:0] expResult;
        logic [2:0]  expFlags;
        int          expLatency;
    } vector_t;

    logic    clk = 1'b0;
    logic    reset;
    int      checks = 0;
    int      fails = 0;
    vector_t vectors[NUM_VEC];

    always #5 clk = ~clk;

    normalize_round_if #(.SIG_BITS(SIG_BITS), .EXP_BITS(EXP_BITS)) bus ();

    normalize_round #(.SIG_BITS(SIG_BITS), .EXP_BITS(EXP_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Offers one operation, waits for the accept, then counts edges until out_valid.
    task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [27:0] g, output int latency);
        int waitCnt;
        waitCnt = 0;
        @(negedge clk);
        bus.sign_in  = s;
        bus.exp_in   = e;
        bus.sig_in   = g;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            latency = -1;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("in_ready_busy", 64'(bus.in_ready), 64'(0));
        latency = 0;
        while (latency < 64) begin
            if (bus.out_valid) break;
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic releaseOutput();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("out_valid_cleared", 64'(bus.out_valid), 64'(0));
    endtask

    task automatic runVector(input int idx);
        int lat;
        applyStimulus(vectors[idx].signIn, vectors[idx].expIn, vectors[idx].sigIn, lat);
        checkOutput($sformatf("v%0d_latency", idx), 64'(lat), 64'(vectors[idx].expLatency));
        checkOutput($sformatf("v%0d_result", idx), 64'(bus.result), 64'(vectors[idx].expResult));
        checkOutput($sformatf("v%0d_flags", idx), 64'({bus.overflow, bus.underflow, bus.inexact}),
                    64'(vectors[idx].expFlags));
        releaseOutput();
    endtask

    initial begin
        int lat;
        // flags are {overflow, underflow, inexact}
        vectors[0]  = '{1'b0, 8'd127, 28'h4000008, 32'h3F800001, 3'b000, 2};
        vectors[1]  = '{1'b0, 8'd127, 28'h8000000, 32'h40000000, 3'b000, 2};
        vectors[2]  = '{1'b0, 8'd130, 28'h0400000, 32'h3F000000, 3'b000, 6};
        vectors[3]  = '{1'b0, 8'd127, 28'h4000004, 32'h3F800000, 3'b001, 2};
        vectors[4]  = '{1'b0, 8'd127, 28'h400000C, 32'h3F800002, 3'b001, 2};
        vectors[5]  = '{1'b0, 8'd254, 28'h7FFFFFC, 32'h7F800000, 3'b101, 2};
        vectors[6]  = '{1'b1, 8'd2,   28'h0000008, 32'h80000000, 3'b011, 2};
        vectors[7]  = '{1'b1, 8'd100, 28'h0000000, 32'h80000000, 3'b000, 1};
        vectors[8]  = '{1'b0, 8'd127, 28'h800000C, 32'h40000001, 3'b001, 2};
        vectors[9]  = '{1'b0, 8'd254, 28'hFFFFFF8, 32'h7F800000, 3'b101, 2};
        vectors[10] = '{1'b0, 8'd3,   28'h0000010, 32'h00000000, 3'b011, 3};
        vectors[11] = '{1'b0, 8'd140, 28'h0200001, 32'h43800004, 3'b000, 7};
        vectors[12] = '{1'b0, 8'd2,   28'h2000000, 32'h00800000, 3'b000, 3};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.sign_in   = 1'b0;
        bus.exp_in    = '0;
        bus.sig_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'(0));
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("reset_result", 64'(bus.result), 64'(0));
        checkOutput("reset_flags", 64'({bus.overflow, bus.underflow, bus.inexact}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("idle_in_ready", 64'(bus.in_ready), 64'(1));

        for (int i = 0; i < NUM_VEC; i++) begin
            runVector(i);
        end

        // Backpressure: result must stay put while the consumer stalls.
        applyStimulus(1'b0, 8'd127, 28'h4000008, lat);
        checkOutput("bp_latency", 64'(lat), 64'(2));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp_result_%0d", c), 64'(bus.result), 64'(32'h3F800001));
            checkOutput($sformatf("bp_out_valid_%0d", c), 64'(bus.out_valid), 64'(1));
            checkOutput($sformatf("bp_in_ready_%0d", c), 64'(bus.in_ready), 64'(0));
        end
        releaseOutput();

        // Reset in the middle of a long left-shift sequence.
        @(negedge clk);
        bus.sign_in  = 1'b0;
        bus.exp_in   = 8'd130;
        bus.sig_in   = 28'h0400000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_reset_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("mid_reset_result", 64'(bus.result), 64'(0));
        checkOutput("mid_reset_in_ready", 64'(bus.in_ready), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", 64'(bus.in_ready), 64'(1));
        repeat (8) @(posedge clk);
        #1;
        checkOutput("post_reset_no_result", 64'(bus.out_valid), 64'(0));
        runVector(4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/normalize_round.md
Name: normalize_round

Overview:
- Post-add normalization and rounding stage of the FP add/sub datapath.
- It is the counterpart of align_significands: that block right-shifts the smaller significand into guard/round/sticky positions. This block takes the raw sum significand with its carry, hidden, fraction and G/R/S bits, and restores a normalized IEEE-754 result.
- Normalization is iterative, one bit position per cycle. It is followed by round-to-nearest-even, then overflow/underflow handling.
- Uses valid/ready handshakes on both sides. Processes one operation at a time.

Parameters:
SIG_BITS, 23, stored fraction width
EXP_BITS, 8, biased exponent width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  input operation present
in_ready  output  1  block can accept an operation
sign_in  input  1  sign of the sum
exp_in  input  EXP_BITS  biased exponent of the larger operand
sig_in  input  SIG_BITS+5  bits as follows: [SIG_BITS+4] carry, [SIG_BITS+3] hidden, [SIG_BITS+2:3] fraction, [2:0] G,R,S
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  1+EXP_BITS+SIG_BITS  {sign, exp, frac}
overflow  output  1  result overflowed to infinity
underflow  output  1  result flushed to zero
inexact  output  1  nonzero bits were discarded

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - state = IDLE
  - out_valid = 0, result = 0, all flags = 0
  - in_ready = 0 while reset is high
- Internal exponent: EXP_BITS+1 bits unsigned. A sticky-accumulating significand register has the same width as sig_in.
- IDLE: in_ready = 1.
  - On in_valid & in_ready, latch sign, exp and sig, then go to NORM.
  - in_ready = 0 in every other state.
- NORM: one decision per cycle, evaluated in priority order:
  - sig == 0: result = {sign, 0, 0}, no flags; go to DONE.
  - Carry set: sig >>= 1, with the shifted-out bit ORed into S; exp += 1; go to ROUND.
  - Hidden set: go to ROUND.
  - exp <= 1: flush to zero. result = {sign, 0, 0}, underflow = 1, inexact = 1; go to DONE.
  - Otherwise: sig <<= 1 (zero fill), exp -= 1; stay in NORM. At most SIG_BITS+3 shifts.
- ROUND (1 cycle):
  - round_up = G & (R | S | frac LSB).
  - inexact = G | R | S.
  - Add round_up to {hidden, frac}. If this carries out, frac = 0 and exp += 1.
  - If exp >= 2^EXP_BITS - 1: result = {sign, all ones, 0}, overflow = 1, inexact = 1.
  - Otherwise result = {sign, exp[EXP_BITS-1:0], frac}.
  - Go to DONE.
- DONE: out_valid = 1. result and flags are held stable until out_ready.
  - On out_ready, go to IDLE and clear out_valid in the same edge.
  - Flags are cleared when the next operation is accepted.
- Latency from the accept edge to out_valid high:
  - zero input: 1 cycle
  - carry or already-normalized input: 2 cycles
  - k left shifts: k+2 cycles
  - underflow flush after k shifts: k+1 cycles
- No overlap: a new input is accepted only in IDLE, so the earliest accept is the cycle after out_valid & out_ready.
- Reset mid-operation (any state): returns to IDLE on the next edge and drops the in-flight result.
- exp_in all ones is outside the contract. The only requirement is that it drives overflow via the ROUND rule.

Test Plan (SIG_BITS=23, EXP_BITS=8):
- Normalized, exact: sig_in=0x4000008, exp_in=127, sign_in=0 -> result=0x3F800001, all flags 0, out_valid 2 cycles after accept.
- Carry: sig_in=0x8000000, exp_in=127 -> result=0x40000000, inexact=0, latency 2.
- Left shift: sig_in=0x0400000, exp_in=130 -> 4 shifts, result=0x3F000000, out_valid 6 cycles after accept.
- RNE:
  - Tie, even LSB: sig_in=0x4000004, exp=127 -> 0x3F800000, inexact=1.
  - Odd LSB: sig_in=0x400000C -> 0x3F800002, inexact=1.
- Overflow: sig_in=0x7FFFFFC, exp_in=254 -> mantissa carry, result=0x7F800000, overflow=1, inexact=1.
- Underflow, backpressure and reset:
  - Underflow: sig_in=0x0000008, exp_in=2, sign_in=1 -> result=0x80000000, underflow=1.
  - Backpressure: hold out_ready=0 for 5 cycles -> result stable and in_ready=0 throughout.
  - Reset: assert reset during NORM -> next cycle state IDLE, out_valid=0, result=0.
